// File: rtl/ysyx_22050598_clint.sv
// Core-local interruptor (msip / mtimecmp / mtime) behind an AXI4 responder.
// Define YSYX_22050598_CLINT_TICK_DIV_EN to advance mtime once per TICK_DIV clocks.
module ysyx_22050598_clint #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        S_AXI_AWID,
  input  logic [63:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic [3:0]  S_AXI_AWCACHE,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic [3:0]  S_AXI_AWQOS,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [63:0] S_AXI_WDATA,
  input  logic [7:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic        S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic        S_AXI_ARID,
  input  logic [63:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic [3:0]  S_AXI_ARCACHE,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic [3:0]  S_AXI_ARQOS,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic        S_AXI_RID,
  output logic [63:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        timer_irq,
  output logic        soft_irq
);

  typedef enum logic [1:0] {REG_MSIP, REG_CMP, REG_TIME, REG_NONE} reg_sel_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Addresses are kept as 8-byte word indices; the low three bits never matter.
  function automatic reg_sel_t decode(input logic [60:0] a);
    logic [60:0] off;
    off = a - BASE_ADDR[63:3];
    case (off)
      61'h0:    decode = REG_MSIP;
      61'h800:  decode = REG_CMP;
      61'h17FF: decode = REG_TIME;
      default:  decode = REG_NONE;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [7:0] strb);
    merge = old;
    for (int unsigned i = 0; i < 8; i++)
      if (strb[i]) merge[i*8 +: 8] = data[i*8 +: 8];
  endfunction

  logic [63:0] mtime, mtimecmp;
  logic        msip;
  logic        tick;

  w_state_t    w_state;
  logic [60:0] w_addr;
  logic        w_err;
  reg_sel_t    w_sel;
  logic        w_fire;

  r_state_t    r_state;
  logic [60:0] r_addr;
  logic [7:0]  r_len, r_cnt;
  logic [60:0] rd_addr;
  logic [63:0] rd_word;
  logic        rd_err;

  logic unused_sig;
  assign unused_sig = ^{S_AXI_AWADDR[2:0], S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                        S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_ARADDR[2:0],
                        S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARCACHE, S_AXI_ARPROT,
                        S_AXI_ARQOS, 32'(TICK_DIV)};

  assign S_AXI_AWREADY = !rst && (w_state == W_IDLE);
  assign S_AXI_WREADY  = (w_state == W_DATA);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_ARREADY = !rst && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RLAST   = (r_state == R_DATA) && (r_cnt == r_len);
  assign soft_irq      = msip;

  assign w_sel  = decode(w_addr);
  assign w_fire = (w_state == W_DATA) && S_AXI_WVALID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_IDLE;
      w_addr      <= '0;
      w_err       <= 1'b0;
      S_AXI_BID   <= 1'b0;
      S_AXI_BRESP <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: if (S_AXI_AWVALID) begin
          w_addr    <= S_AXI_AWADDR[63:3];
          S_AXI_BID <= S_AXI_AWID;
          w_err     <= 1'b0;
          w_state   <= W_DATA;
        end
        W_DATA: if (S_AXI_WVALID) begin
          w_addr <= w_addr + 61'd1;
          w_err  <= w_err | (w_sel == REG_NONE);
          if (S_AXI_WLAST) begin
            S_AXI_BRESP <= (w_err || (w_sel == REG_NONE)) ? 2'b10 : 2'b00;
            w_state     <= W_RESP;
          end
        end
        default: if (S_AXI_BREADY) w_state <= W_IDLE;
      endcase
    end
  end

`ifdef YSYX_22050598_CLINT_TICK_DIV_EN
  logic [15:0] prescale;
  assign tick = (prescale == 16'(TICK_DIV - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prescale <= '0;
    else     prescale <= tick ? '0 : prescale + 16'd1;
  end
`else
  assign tick = 1'b1;
`endif

  // A write to mtime overrides that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
      if (w_fire && (w_sel == REG_TIME)) mtime <= merge(mtime, S_AXI_WDATA, S_AXI_WSTRB);
      else if (tick)                    mtime <= mtime + 64'd1;
      if (w_fire && (w_sel == REG_CMP))  mtimecmp <= merge(mtimecmp, S_AXI_WDATA, S_AXI_WSTRB);
      if (w_fire && (w_sel == REG_MSIP) && S_AXI_WSTRB[0]) msip <= S_AXI_WDATA[0];
    end
  end

  assign rd_addr = (r_state == R_IDLE) ? S_AXI_ARADDR[63:3] : r_addr + 61'd1;

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (decode(rd_addr))
      REG_MSIP: rd_word = {63'd0, msip};
      REG_CMP:  rd_word = mtimecmp;
      REG_TIME: rd_word = mtime;
      default:  rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      S_AXI_RID   <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: if (S_AXI_ARVALID) begin
          r_addr      <= S_AXI_ARADDR[63:3];
          r_len       <= S_AXI_ARLEN;
          r_cnt       <= '0;
          S_AXI_RID   <= S_AXI_ARID;
          S_AXI_RDATA <= rd_word;
          S_AXI_RRESP <= rd_err ? 2'b10 : 2'b00;
          r_state     <= R_DATA;
        end
        default: if (S_AXI_RREADY) begin
          if (r_cnt == r_len) begin
            r_state <= R_IDLE;
          end else begin
            r_addr      <= r_addr + 61'd1;
            r_cnt       <= r_cnt + 8'd1;
            S_AXI_RDATA <= rd_word;
            S_AXI_RRESP <= rd_err ? 2'b10 : 2'b00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_clint.sv
// Directed bench for ysyx_22050598_clint; prescaler case runs when
// YSYX_22050598_CLINT_TICK_DIV_EN is defined.
module tb_ysyx_22050598_clint;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

  logic clk = 1'b0, rst = 1'b1;
  logic awid = 0, awvalid = 0, awready;
  logic [63:0] awaddr = '0;
  logic [7:0] awlen = '0;
  logic [63:0] wdata = '0;
  logic [7:0] wstrb = '0;
  logic wlast = 0, wvalid = 0, wready;
  logic bid, bvalid, bready = 0;
  logic [1:0] bresp;
  logic arid = 0, arvalid = 0, arready;
  logic [63:0] araddr = '0;
  logic [7:0] arlen = '0;
  logic rid, rlast, rvalid, rready = 0;
  logic [63:0] rdata;
  logic [1:0] rresp;
  logic timer_irq, soft_irq;

  int total = 0, bad = 0, cyc = 0, rel = 0;

  ysyx_22050598_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(3'd3),
    .S_AXI_AWBURST(2'b01), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWQOS(4'd0),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(3'd3),
    .S_AXI_ARBURST(2'b01), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Up to two beats; w_edge is the clock edge number of the last W handshake.
  task automatic axi_write(input logic [63:0] addr, input int beats, input logic id,
                           input logic [63:0] d0, input logic [7:0] s0,
                           input logic [63:0] d1, input logic [7:0] s1,
                           output logic [1:0] resp, output logic rsp_id, output int w_edge);
    int n;
    resp = 2'bxx; rsp_id = 1'bx; w_edge = 0;
    @(negedge clk);
    awaddr = addr; awid = id; awlen = 8'(beats - 1); awvalid = 1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin
      total++; bad++; awvalid = 0;
      $display("FAIL aw_timeout: awready=%0b required=1", awready);
      return;
    end
    @(posedge clk); #1 awvalid = 0;
    for (int b = 0; b < beats; b++) begin
      wdata = (b == 0) ? d0 : d1; wstrb = (b == 0) ? s0 : s1;
      wlast = (b == beats - 1); wvalid = 1;
      @(negedge clk);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin
        total++; bad++; wvalid = 0;
        $display("FAIL w_timeout: wready=%0b required=1", wready);
        return;
      end
      w_edge = cyc + 1;
      @(posedge clk); #1 wvalid = 0; wlast = 0;
    end
    bready = 1;
    @(negedge clk);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin
      total++; bad++; bready = 0;
      $display("FAIL b_timeout: bvalid=%0b required=1", bvalid);
      return;
    end
    resp = bresp; rsp_id = bid;
    @(posedge clk); #1 bready = 0;
  endtask

  // lat1: RVALID already high one cycle after AR; stable: beat 0 unchanged while held.
  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic id,
                          input int hold, output logic [3:0][63:0] d,
                          output logic [3:0][1:0] rr, output logic [3:0] rl,
                          output logic [3:0] ri, output int ar_edge,
                          output bit lat1, output bit stable);
    int n;
    logic [63:0] d0;
    logic [1:0] r0;
    d = '1; rr = '1; rl = '1; ri = '1; ar_edge = 0; lat1 = 0; stable = 1;
    @(negedge clk);
    araddr = addr; arlen = len; arid = id; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin
      total++; bad++; arvalid = 0;
      $display("FAIL ar_timeout: arready=%0b required=1", arready);
      return;
    end
    ar_edge = cyc + 1;
    @(posedge clk); #1 arvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      if (b == 0) lat1 = rvalid;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (!rvalid) begin
        total++; bad++;
        $display("FAIL r_timeout: rvalid=%0b required=1", rvalid);
        return;
      end
      if (b == 0) begin
        d0 = rdata; r0 = rresp;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (rdata !== d0 || rresp !== r0 || rvalid !== 1'b1) stable = 0;
        end
      end
      d[b] = rdata; rr[b] = rresp; rl[b] = rlast; ri[b] = rid;
      rready = 1;
      @(posedge clk); #1 rready = 0;
    end
  endtask

  task automatic test_reset();
    logic [3:0][63:0] d; logic [3:0][1:0] rr; logic [3:0] rl, ri;
    int ae; bit l1, st;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({awready, wready, arready} !== 3'b000) begin
      bad++; $display("FAIL reset_ready: got=%b required=000", {awready, wready, arready});
    end
    total++;
    if ({bvalid, rvalid, rlast, timer_irq, soft_irq} !== 5'b0) begin
      bad++; $display("FAIL reset_valid_irq: got=%b required=00000",
                      {bvalid, rvalid, rlast, timer_irq, soft_irq});
    end
    total++;
    if ({rdata, rresp, bresp, rid, bid} !== 70'd0) begin
      bad++; $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b", rdata, rresp, bresp);
    end
    rst = 0; rel = cyc;
`ifdef YSYX_22050598_CLINT_TICK_DIV_EN
    repeat (40) @(posedge clk);
`else
    repeat (10) @(posedge clk);
`endif
    axi_read(BASE + 64'hBFF8, 8'd0, 1'b0, 0, d, rr, rl, ri, ae, l1, st);
    total++;
    if (d[0] !== 64'd10) begin
      bad++; $display("FAIL reset_mtime: got=%0d required=10", d[0]);
    end
    total++;
    if ({l1, rr[0], rl[0]} !== 4'b1001) begin
      bad++; $display("FAIL reset_read_resp: lat1/rresp/rlast got=%b required=1001",
                      {l1, rr[0], rl[0]});
    end
  endtask

  task automatic test_mtime_write();
    logic [3:0][63:0] d; logic [3:0][1:0] rr; logic [3:0] rl, ri;
    logic [1:0] resp; logic bi; int we, ae; bit l1, st;
    axi_write(BASE + 64'hBFF8, 1, 1'b1, 64'd1000, 8'hFF, 64'd0, 8'h00, resp, bi, we);
    axi_read(BASE + 64'hBFF8, 8'd0, 1'b0, 0, d, rr, rl, ri, ae, l1, st);
    total++;
    if (d[0] !== 64'd1000 + 64'(ae - 1 - we)) begin
      bad++; $display("FAIL mtime_write: got=%0d required=%0d", d[0], 1000 + ae - 1 - we);
    end
    total++;
    if ({resp, bi} !== 3'b001) begin
      bad++; $display("FAIL mtime_write_b: bresp/bid got=%b required=001", {resp, bi});
    end
  endtask

  task automatic test_timer();
    logic [1:0] resp; logic bi; int we;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0; rel = cyc;
    axi_write(BASE + 64'h4000, 1, 1'b0, 64'd20, 8'hFF, 64'd0, 8'h00, resp, bi, we);
    while (cyc < rel + 20) @(negedge clk);
    total++;
    if (timer_irq !== 1'b0) begin
      bad++; $display("FAIL timer_before: got=%b required=0", timer_irq);
    end
    @(negedge clk);
    total++;
    if (timer_irq !== 1'b1) begin
      bad++; $display("FAIL timer_rise: got=%b required=1", timer_irq);
    end
    axi_write(BASE + 64'h4000, 1, 1'b0, '1, 8'hFF, 64'd0, 8'h00, resp, bi, we);
    total++;
    if (timer_irq !== 1'b0) begin
      bad++; $display("FAIL timer_drop: got=%b required=0", timer_irq);
    end
  endtask

  task automatic test_msip();
    logic [3:0][63:0] d; logic [3:0][1:0] rr; logic [3:0] rl, ri;
    logic [1:0] resp; logic bi; int we, ae; bit l1, st;
    axi_write(BASE, 1, 1'b0, '1, 8'hFF, 64'd0, 8'h00, resp, bi, we);
    total++;
    if (soft_irq !== 1'b1) begin
      bad++; $display("FAIL msip_set: soft_irq=%b required=1", soft_irq);
    end
    axi_read(BASE, 8'd0, 1'b0, 0, d, rr, rl, ri, ae, l1, st);
    total++;
    if (d[0] !== 64'd1 || rr[0] !== 2'b00) begin
      bad++; $display("FAIL msip_read: got=%h/%b required=1/00", d[0], rr[0]);
    end
    axi_write(BASE, 1, 1'b0, 64'd0, 8'hFF, 64'd0, 8'h00, resp, bi, we);
    total++;
    if (soft_irq !== 1'b0) begin
      bad++; $display("FAIL msip_clear: soft_irq=%b required=0", soft_irq);
    end
  endtask

  task automatic test_burst_read();
    logic [3:0][63:0] d; logic [3:0][1:0] rr; logic [3:0] rl, ri;
    logic [1:0] resp; logic bi; int we, ae; bit l1, st;
    axi_write(BASE + 64'h4000, 1, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 8'h00,
              resp, bi, we);
    axi_read(BASE + 64'h3FF8, 8'd1, 1'b1, 3, d, rr, rl, ri, ae, l1, st);
    total++;
    if ({l1, st} !== 2'b11) begin
      bad++; $display("FAIL burst_hold: lat1/stable got=%b required=11", {l1, st});
    end
    total++;
    if (d[0] !== 64'd0 || rr[0] !== 2'b10 || rl[0] !== 1'b0) begin
      bad++; $display("FAIL burst_beat0: got=%h/%b/%b required=0/10/0", d[0], rr[0], rl[0]);
    end
    total++;
    if (d[1] !== 64'h0123_4567_89AB_CDEF || rr[1] !== 2'b00 || rl[1] !== 1'b1) begin
      bad++; $display("FAIL burst_beat1: got=%h/%b/%b required=0123456789abcdef/00/1",
                      d[1], rr[1], rl[1]);
    end
    total++;
    if (ri[1:0] !== 2'b11) begin
      bad++; $display("FAIL burst_rid: got=%b required=11", ri[1:0]);
    end
  endtask

  task automatic test_strobe_unmapped();
    logic [3:0][63:0] d; logic [3:0][1:0] rr; logic [3:0] rl, ri;
    logic [1:0] resp; logic bi; int we, ae; bit l1, st;
    axi_write(BASE + 64'h4000, 1, 1'b0, '1, 8'hFF, 64'd0, 8'h00, resp, bi, we);
    axi_write(BASE + 64'h4000, 1, 1'b0, 64'h1234_5678, 8'h0F, 64'd0, 8'h00, resp, bi, we);
    axi_read(BASE + 64'h4000, 8'd0, 1'b0, 0, d, rr, rl, ri, ae, l1, st);
    total++;
    if (d[0] !== 64'hFFFF_FFFF_1234_5678) begin
      bad++; $display("FAIL strobe: got=%h required=ffffffff12345678", d[0]);
    end
    axi_write(BASE + 64'h8000, 1, 1'b1, 64'd0, 8'hFF, 64'd0, 8'h00, resp, bi, we);
    total++;
    if ({resp, bi} !== 3'b101) begin
      bad++; $display("FAIL unmapped_b: bresp/bid got=%b required=101", {resp, bi});
    end
    axi_read(BASE + 64'h4000, 8'd0, 1'b0, 0, d, rr, rl, ri, ae, l1, st);
    total++;
    if (d[0] !== 64'hFFFF_FFFF_1234_5678 || soft_irq !== 1'b0) begin
      bad++; $display("FAIL unmapped_nochange: cmp=%h soft=%b", d[0], soft_irq);
    end
    axi_read(BASE + 64'h8000, 8'd0, 1'b0, 0, d, rr, rl, ri, ae, l1, st);
    total++;
    if (d[0] !== 64'd0 || rr[0] !== 2'b10) begin
      bad++; $display("FAIL unmapped_read: got=%h/%b required=0/10", d[0], rr[0]);
    end
  endtask

  task automatic test_burst_write();
    logic [3:0][63:0] d; logic [3:0][1:0] rr; logic [3:0] rl, ri;
    logic [1:0] resp; logic bi; int we, ae; bit l1, st;
    axi_write(BASE + 64'h3FF8, 2, 1'b1, 64'h55, 8'hFF, 64'hA5, 8'hFF, resp, bi, we);
    total++;
    if ({resp, bi} !== 3'b101) begin
      bad++; $display("FAIL bwrite_b: bresp/bid got=%b required=101", {resp, bi});
    end
    axi_read(BASE + 64'h4000, 8'd0, 1'b0, 0, d, rr, rl, ri, ae, l1, st);
    total++;
    if (d[0] !== 64'hA5) begin
      bad++; $display("FAIL bwrite_cmp: got=%h required=a5", d[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][63:0] d; logic [3:0][1:0] rr; logic [3:0] rl, ri;
    int n, ae; bit l1, st;
    @(negedge clk);
    araddr = BASE + 64'hBFF8; arlen = 8'd0; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 arvalid = 0;
    @(negedge clk);
    total++;
    if (rvalid !== 1'b1) begin
      bad++; $display("FAIL mid_rvalid_pre: got=%b required=1", rvalid);
    end
    @(posedge clk); #1 rst = 1;
    #1;
    total++;
    if ({rvalid, arready, awready} !== 3'b000) begin
      bad++; $display("FAIL mid_reset_drop: rvalid/arready/awready got=%b required=000",
                      {rvalid, arready, awready});
    end
    @(negedge clk);
    rst = 0; rel = cyc;
    axi_read(BASE + 64'hBFF8, 8'd0, 1'b0, 0, d, rr, rl, ri, ae, l1, st);
    total++;
`ifdef YSYX_22050598_CLINT_TICK_DIV_EN
    if (d[0] !== 64'd0) begin
      bad++; $display("FAIL mid_mtime: got=%0d required=0", d[0]);
    end
`else
    if (d[0] !== 64'd1) begin
      bad++; $display("FAIL mid_mtime: got=%0d required=1", d[0]);
    end
`endif
  endtask

  initial begin
    test_reset();
`ifndef YSYX_22050598_CLINT_TICK_DIV_EN
    test_mtime_write();
    test_timer();
`endif
    test_msip();
    test_burst_read();
    test_strobe_unmapped();
    test_burst_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22050598_clint.md
# ysyx_22050598_clint

AXI4 responder (slave) implementing the core-local interruptor: machine timer `mtime`, compare register `mtimecmp` and software-interrupt bit `msip`. It sits on the CPU master bus beside the memory slave; the top-level crossbar routes the CLINT address window to it. It drives `timer_irq` and `soft_irq` to the CPU's CSR/trap logic.

## Interface
- `BASE_ADDR`, 64'h0000_0000_0200_0000: window base; window is `BASE_ADDR`..`BASE_ADDR`+0xFFFF.
- `TICK_DIV`, 16: `mtime` increments once per `TICK_DIV` clocks (only with the macro; must be ≥1).
- `clk` input 1: single clock; everything is posedge.
- `rst` input 1: reset, asynchronous and active-high.
- `S_AXI_AWID` / `S_AXI_AWADDR` / `S_AXI_AWLEN` input 1/64/8: write ID, address, beats−1.
- `S_AXI_AWSIZE`/`AWBURST`/`AWCACHE`/`AWPROT`/`AWQOS` input 3/2/4/3/4: ignored; size is always 8 bytes, burst is always INCR.
- `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: AW handshake.
- `S_AXI_WDATA` / `S_AXI_WSTRB` / `S_AXI_WLAST` input 64/8/1: write beat.
- `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: W handshake.
- `S_AXI_BID` / `S_AXI_BRESP` output 1/2: echoed AWID; OKAY=00, SLVERR=10.
- `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: B handshake.
- `S_AXI_ARID` / `S_AXI_ARADDR` / `S_AXI_ARLEN` input 1/64/8; AR sideband (SIZE/BURST/CACHE/PROT/QOS) ignored.
- `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: AR handshake.
- `S_AXI_RID` / `S_AXI_RDATA` / `S_AXI_RRESP` / `S_AXI_RLAST` output 1/64/2/1.
- `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: R handshake.
- `timer_irq` output 1: registered `mtime >= mtimecmp` (unsigned).
- `soft_irq` output 1: `msip[0]`.

## Operation
- Register map (offset = addr − `BASE_ADDR`, addr[2:0] ignored):
  - 0x0000: `msip`; only bit 0 is writable, other bits read 0.
  - 0x4000: `mtimecmp`.
  - 0xBFF8: `mtime`.
  - Any other offset: unmapped; read returns 0 with SLVERR, write is dropped with SLVERR.
- Reset values: `mtime`=0, `mtimecmp`=all-ones, `msip`=0. All VALID outputs 0, all READY outputs 0, `BRESP`/`RRESP`/`RDATA`/`RID`/`BID`/`RLAST` 0, both irqs 0.
- Write FSM:
  - W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: `AWREADY`=1. AW handshake latches addr/len/id.
  - W_DATA: `WREADY`=1. Each W handshake applies `WSTRB` bytewise to the register at the current address, then addr += 8. The burst ends on the `WLAST` beat; `AWLEN` is not checked against the beat count.
  - W_RESP: `BVALID`=1 and held until `BREADY`. `BRESP`=SLVERR if any beat hit an unmapped offset, else OKAY.
  - W beats presented before the AW handshake are not accepted (`WREADY`=0).
- Read FSM:
  - R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: `ARREADY`=1. AR handshake latches addr/len/id and a beat counter of 0, and snapshots the first word into `RDATA`/`RRESP`.
  - R_DATA: `RVALID`=1. `RLAST`=(counter==len). On each R handshake that is not the last beat: addr += 8, counter++, next word snapshotted. The last handshake returns to R_IDLE.
- The read and write FSMs are independent and may be active simultaneously.
- Timer: `mtime` increments by 1 each tick and wraps from all-ones to 0.

## Timing
- READY outputs are 0 while `rst` is high and equal (FSM==IDLE) otherwise.
- Read latency: AR handshake in cycle N → `RVALID` in N+1. Data is `mtime` as it stood in cycle N.
- `RDATA` is held stable while `RVALID` && !`RREADY`, even as `mtime` advances.
- Write: a W handshake in cycle N updates the register at the end of cycle N. Last beat in N → `BVALID` in N+1.
- Back-to-back: a new AR/AW is accepted no earlier than the cycle after R_IDLE/W_IDLE is re-entered.
- Write to `mtime` in a tick cycle: the written value wins; incrementing resumes at the next tick.
- Same-cycle read snapshot and write to one register: the snapshot sees the old value.
- `timer_irq` lags register state by 1 cycle.
- Reset asserted mid-transaction: both FSMs go to IDLE immediately, VALIDs drop, and the in-flight transaction is discarded with no response.

## Configuration
- Macro `YSYX_22050598_CLINT_TICK_DIV_EN`.
- Defined: a 16-bit prescaler counts 0..`TICK_DIV`−1 and `mtime` increments when it wraps. The prescaler resets to 0 and is unaffected by `mtime` writes.
- Undefined: `mtime` increments every cycle, `TICK_DIV` is unused, and no prescaler logic exists.

## Test plan
- Reset release, macro off, idle 10 cycles, then single read of 0xBFF8 → `RDATA`=10 (±handshake offset exactly as specified), `RRESP`=00, `RLAST`=1.
- Write `mtimecmp`=20 with WSTRB=FF, `mtime` running from 0 → `timer_irq` rises in the cycle after `mtime` reaches 20; writing `mtimecmp`=all-ones drops it the cycle after the write.
- Write 0x0000 with data 0xFFFF_FFFF_FFFF_FFFF → `soft_irq`=1; read back 0x0000 → 0x1; write 0 → `soft_irq`=0.
- Burst read ARLEN=1 at 0x3FF8 with `RREADY` held low 3 cycles → beat0 SLVERR/0 stable throughout, beat1 `mtimecmp` with `RLAST`=1, `RID` echoes `ARID`.
- Write `WSTRB`=0x0F, data 0x1234_5678 to `mtimecmp` (all-ones) → reads 0xFFFF_FFFF_1234_5678; write to 0x8000 → `BRESP`=10, no register changes.
- Macro on, `TICK_DIV`=4: 40 cycles after reset `mtime`=10; assert `rst` while `RVALID`=1 → `RVALID`=0 immediately, `mtime`=0.
